// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared types and helpers for the SPI register-protocol
//               initiator: mode struct, controller state encoding and the
//               sample/change edge classifier.
// Revision    : 1.0  initial release
// ============================================================================
package spi_pkg;

    // {CPOL, CPHA}, bit order matches the 2-bit mode port.
    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } spi_ctrl_state_t;

    // Edge 0 is the leading edge of the first bit. CPHA=0 samples on leading
    // edges (even counts); CPHA=1 samples on trailing edges (odd counts).
    // Only the count LSB decides, so only that bit is passed in.
    function automatic logic is_sample_edge(input logic cpha, input logic edge_cnt_lsb);
        return cpha ? edge_cnt_lsb : ~edge_cnt_lsb;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sclk_divider.sv
`default_nettype none
// ============================================================================
// Module      : spi_sclk_divider
// Description : Half-period tick generator. Emits a one-cycle tick every
//               HALF_PERIOD enabled clk cycles; clear forces a fresh count.
// Ports       : clk, rstb (sync, active-low), run (count enable),
//               clear (restart count), tick (end-of-half-period strobe)
// Revision    : 1.0  initial release
// ============================================================================
module spi_sclk_divider #(
    parameter int HALF_PERIOD = 4
) (
    input  logic clk,
    input  logic rstb,
    input  logic run,
    input  logic clear,
    output logic tick
);

    localparam int                 c_CNT_W = $clog2(HALF_PERIOD);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(HALF_PERIOD - 1);

    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rstb) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (run) begin
            r_cnt <= (r_cnt == c_LAST) ? '0 : r_cnt + 1'b1;
        end
    end

    assign tick = run && (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/spi_controller.sv
`default_nettype none
// ============================================================================
// Module      : spi_controller
// Description : SPI initiator for the 2-byte register protocol.
//               Frame = cs_n low, byte0 {wr_rdn, addr}, byte1 data, MSB first.
//               byte0 returns status, byte1 returns read data.
// Ports       : clk, rstb (sync, active-low), ena (global clock enable)
//               mode {CPOL,CPHA}, req/wr_rdn/addr/wdata (request side)
//               busy, done, rdata, status (completion side)
//               spi_sclk, spi_cs_n, spi_mosi, spi_miso (SPI pins)
// Revision    : 1.0  initial release
// ============================================================================
module spi_controller
    import spi_pkg::*;
#(
    parameter int REG_W       = 8,
    parameter int HALF_PERIOD = 4,
    parameter int CS_GAP      = 4
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             ena,
    input  logic [1:0]       mode,
    input  logic             req,
    input  logic             wr_rdn,
    input  logic [REG_W-2:0] addr,
    input  logic [REG_W-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [REG_W-1:0] rdata,
    output logic [REG_W-1:0] status,
    output logic             spi_sclk,
    output logic             spi_cs_n,
    output logic             spi_mosi,
    input  logic             spi_miso
);

    localparam int                  c_FRAME_W   = 2 * REG_W;
    localparam int                  c_EDGES     = 4 * REG_W;
    localparam int                  c_EDGE_W    = $clog2(c_EDGES);
    localparam logic [c_EDGE_W-1:0] c_LAST_EDGE = c_EDGE_W'(c_EDGES - 1);
    localparam int                  c_GAP_W     = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
    localparam logic [c_GAP_W-1:0]  c_GAP_LAST  = c_GAP_W'(CS_GAP - 1);

    spi_ctrl_state_t      r_state;
    spi_mode_t            r_mode;
    logic                 r_wr;
    logic [c_FRAME_W-1:0] r_tx;
    logic [c_FRAME_W-1:0] r_rx;
    logic [c_EDGE_W-1:0]  r_edge_cnt;
    logic [c_GAP_W-1:0]   r_gap_cnt;
    logic                 r_busy;
    logic                 r_done;
    logic [REG_W-1:0]     r_rdata;
    logic [REG_W-1:0]     r_status;
    logic                 r_sclk;
    logic                 r_cs_n;
    logic                 r_mosi;

    logic                 w_timed;
    logic                 w_tick;
    logic                 w_sample;
    logic                 w_skip_change;
    logic [c_FRAME_W-1:0] w_rx_final;

    // The divider only runs while a timed phase is active; any other state
    // holds it at zero so every phase starts with a full half period.
    assign w_timed = (r_state == SETUP) || (r_state == SHIFT) || (r_state == HOLD);

    spi_sclk_divider #(
        .HALF_PERIOD (HALF_PERIOD)
    ) u_div (
        .clk   (clk),
        .rstb  (rstb),
        .run   (ena && w_timed),
        .clear (!w_timed),
        .tick  (w_tick)
    );

    assign w_sample = is_sample_edge(r_mode.cpha, r_edge_cnt[0]);

    // The first bit is already on MOSI from the accept cycle, so one change
    // edge per frame is skipped: the first for CPHA=1, the last for CPHA=0.
    assign w_skip_change = r_mode.cpha ? (r_edge_cnt == '0) : (r_edge_cnt == c_LAST_EDGE);

    // With CPHA=1 the final edge is also a sample edge; include that bit.
    assign w_rx_final = w_sample ? {r_rx[c_FRAME_W-2:0], spi_miso} : r_rx;

    always_ff @(posedge clk) begin
        if (!rstb) begin
            r_state    <= IDLE;
            r_mode     <= '0;
            r_wr       <= 1'b0;
            r_tx       <= '0;
            r_rx       <= '0;
            r_edge_cnt <= '0;
            r_gap_cnt  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_rdata    <= '0;
            r_status   <= '0;
            r_sclk     <= 1'b0;
            r_cs_n     <= 1'b1;
            r_mosi     <= 1'b0;
        end else if (ena) begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_sclk <= mode[1];
                    // r_done blocks accept in the done cycle itself.
                    if (req && !r_done) begin
                        r_mode  <= spi_mode_t'(mode);
                        r_wr    <= wr_rdn;
                        r_tx    <= {wr_rdn, addr, wdata & {REG_W{wr_rdn}}};
                        r_mosi  <= wr_rdn;
                        r_cs_n  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= SETUP;
                    end
                end
                SETUP: begin
                    if (w_tick) begin
                        r_edge_cnt <= '0;
                        r_state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (w_tick) begin
                        r_sclk <= ~r_sclk;
                        if (w_sample) begin
                            r_rx <= w_rx_final;
                        end else if (!w_skip_change) begin
                            r_tx   <= r_tx << 1;
                            r_mosi <= r_tx[c_FRAME_W-2];
                        end
                        if (r_edge_cnt == c_LAST_EDGE) begin
                            r_status <= w_rx_final[c_FRAME_W-1:REG_W];
                            if (!r_wr) begin
                                r_rdata <= w_rx_final[REG_W-1:0];
                            end
                            r_state <= HOLD;
                        end else begin
                            r_edge_cnt <= r_edge_cnt + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (w_tick) begin
                        r_sclk    <= r_mode.cpol;
                        r_cs_n    <= 1'b1;
                        r_gap_cnt <= '0;
                        r_state   <= GAP;
                    end
                end
                GAP: begin
                    if (r_gap_cnt == c_GAP_LAST) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign rdata    = r_rdata;
    assign status   = r_status;
    assign spi_sclk = r_sclk;
    assign spi_cs_n = r_cs_n;
    assign spi_mosi = r_mosi;

endmodule
`default_nettype wire

// File: tb/tb_spi_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_controller
// Description : Self-checking bench for spi_controller. A pin-level SPI
//               peripheral model (register file, status byte) answers each
//               frame; a scoreboard of register contents and frame timing
//               predicts every observed value.
// Revision    : 1.0  initial release
// ============================================================================
module tb_spi_controller;

    localparam int REG_W       = 8;
    localparam int HALF_PERIOD = 4;
    localparam int CS_GAP      = 4;

    logic       clk = 1'b0;
    logic       rstb;
    logic       ena;
    logic [1:0] mode;
    logic       req;
    logic       wr_rdn;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic [7:0] rdata;
    logic [7:0] status;
    logic       spi_sclk;
    logic       spi_cs_n;
    logic       spi_mosi;
    logic       spi_miso;

    int n_checks = 0;
    int n_errors = 0;
    int n_done   = 0;

    // peripheral model state
    logic [7:0]  p_mem [128];
    logic [7:0]  p_status;
    bit          p_cpol, p_cpha, p_lead;
    logic [15:0] p_out, p_rx;
    int          p_nrx, p_ntog, p_oidx, p_frames;
    logic        p_prev_cs = 1'b1, p_prev_sclk = 1'b0;
    logic        p_sclk_fall, p_sclk_rise;

    // scoreboard
    logic [7:0] m_mem [128];
    logic [7:0] exp_rdata;

    spi_controller #(
        .REG_W       (REG_W),
        .HALF_PERIOD (HALF_PERIOD),
        .CS_GAP      (CS_GAP)
    ) dut (
        .clk      (clk),
        .rstb     (rstb),
        .ena      (ena),
        .mode     (mode),
        .req      (req),
        .wr_rdn   (wr_rdn),
        .addr     (addr),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .rdata    (rdata),
        .status   (status),
        .spi_sclk (spi_sclk),
        .spi_cs_n (spi_cs_n),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) n_done++;
    end

    // Pin-level peripheral: byte0 out = status, byte1 out = register on read.
    always @(negedge clk) begin
        if (p_prev_cs && !spi_cs_n) begin
            p_nrx = 0; p_ntog = 0; p_oidx = 0; p_rx = '0;
            p_frames++;
            p_sclk_fall = spi_sclk;
            p_out = {p_status, 8'h00};
            if (!p_cpha) begin
                spi_miso = p_out[15];
                p_oidx = 1;
            end
        end else if (!spi_cs_n && spi_sclk != p_prev_sclk) begin
            p_lead = (p_prev_sclk == p_cpol);
            p_ntog++;
            if (p_lead != p_cpha) begin
                p_rx = {p_rx[14:0], spi_mosi};
                p_nrx++;
                if (p_nrx == 8) p_out[7:0] = p_rx[7] ? 8'h00 : p_mem[p_rx[6:0]];
            end else if (p_oidx < 16) begin
                spi_miso = p_out[15 - p_oidx];
                p_oidx++;
            end
        end
        if (!p_prev_cs && spi_cs_n) begin
            p_sclk_rise = spi_sclk;
            if (p_nrx == 16 && p_rx[15]) p_mem[p_rx[14:8]] = p_rx[7:0];
        end
        p_prev_cs   = spi_cs_n;
        p_prev_sclk = spi_sclk;
    end

    task automatic do_frame(input logic [1:0] fmode, input logic fwr, input logic [6:0] faddr,
                            input logic [7:0] fwdata, input logic [7:0] fstatus, input bit disturb,
                            input int ena_at, input int ena_len, input int abort_edge);
        int          cyc, frames0, dones0, abort_cyc, exp_lat;
        bit          got_done, aborted;
        logic [2:0]  snap;
        logic [15:0] exp_tx;
        p_status = fstatus;
        p_cpol   = fmode[1];
        p_cpha   = fmode[0];
        frames0  = p_frames;
        dones0   = n_done;
        exp_tx   = {fwr, faddr, fwr ? fwdata : 8'h00};
        mode = fmode; wr_rdn = fwr; addr = faddr; wdata = fwdata; req = 1'b1;
        cyc = 0; got_done = 0; aborted = 0; abort_cyc = 0; snap = '0;
        while (cyc < 1000 && !got_done && !(aborted && cyc >= abort_cyc + 200)) begin
            @(negedge clk); #1;
            cyc++;
            if (cyc == 1) begin
                req = 1'b0;
                check("busy_after_accept", busy, 1);
            end
            if (disturb && cyc == 40) begin
                req = 1'b1; mode = ~fmode; addr = ~faddr; wdata = ~fwdata; wr_rdn = ~fwr;
            end
            if (disturb && cyc == 41) req = 1'b0;
            if (ena_len > 0 && cyc == ena_at) begin
                snap = {spi_sclk, spi_mosi, spi_cs_n};
                ena = 1'b0;
            end
            if (ena_len > 0 && cyc == ena_at + ena_len) begin
                check("pins_frozen", {spi_sclk, spi_mosi, spi_cs_n}, snap);
                ena = 1'b1;
            end
            if (aborted && cyc == abort_cyc + 1) begin
                check("abort_cs_n", spi_cs_n, 1);
                check("abort_sclk", spi_sclk, 0);
                check("abort_busy", busy, 0);
                rstb = 1'b1;
            end
            if (abort_edge > 0 && !aborted && p_ntog == abort_edge) begin
                rstb = 1'b0;
                aborted = 1;
                abort_cyc = cyc;
            end
            if (done) got_done = 1;
        end
        if (abort_edge > 0) begin
            check("abort_reached", aborted, 1);
            check("abort_no_done", n_done - dones0, 0);
            check("abort_rdata", rdata, 0);
            check("abort_status", status, 0);
            exp_rdata = 8'h00;
        end else begin
            check("done_seen", got_done, 1);
            exp_lat = (2 + 4 * REG_W) * HALF_PERIOD + CS_GAP + 1 + ((ena_len > 0) ? ena_len : 0);
            check("latency", cyc, exp_lat);
            check("frames", p_frames - frames0, 1);
            check("mosi_bytes", p_rx, exp_tx);
            check("sclk_edges", p_ntog, 4 * REG_W);
            check("sclk_idle_before_cs", p_sclk_fall, fmode[1]);
            check("sclk_idle_after_cs", p_sclk_rise, fmode[1]);
            check("status", status, fstatus);
            if (fwr) m_mem[faddr] = fwdata;
            else     exp_rdata = m_mem[faddr];
            check("rdata", rdata, exp_rdata);
            @(negedge clk); #1;
            check("done_one_cycle", done, 0);
            check("idle_after_done", busy, 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v;
        for (int i = 0; i < 128; i++) begin
            v = 8'($urandom);
            p_mem[i] = v;
            m_mem[i] = v;
        end
        exp_rdata = 8'h00;
        p_status = 8'h00; p_cpol = 0; p_cpha = 0; p_frames = 0;
        p_nrx = 0; p_ntog = 0; p_oidx = 0; p_out = '0; p_rx = '0;
        spi_miso = 1'b0;
        rstb = 1'b0; ena = 1'b1; mode = 2'b00; req = 1'b0;
        wr_rdn = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_cs_n", spi_cs_n, 1);
        check("rst_sclk", spi_sclk, 0);
        check("rst_mosi", spi_mosi, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rdata", rdata, 0);
        check("rst_status", status, 0);
        rstb = 1'b1;
        @(negedge clk); #1;

        // mode 0 write 0x15 <- 0xA5
        do_frame(2'b00, 1'b1, 7'h15, 8'hA5, 8'h11, 0, 0, 0, 0);
        // mode 0 read 0x03, peripheral holds 0xC3 and reports status 0x5A
        p_mem[3] = 8'hC3; m_mem[3] = 8'hC3;
        do_frame(2'b00, 1'b0, 7'h03, 8'hFF, 8'h5A, 0, 0, 0, 0);
        check("read_c3", rdata, 8'hC3);
        // loopback in modes 1..3
        for (int m = 1; m < 4; m++) begin
            do_frame(2'(m), 1'b1, 7'h7F, 8'h3C, 8'($urandom), 0, 0, 0, 0);
            do_frame(2'(m), 1'b0, 7'h7F, 8'h00, 8'($urandom), 0, 0, 0, 0);
            check("loopback_3c", rdata, 8'h3C);
        end
        // req pulse and mode/addr/data changes during a busy frame
        do_frame(2'b01, 1'b1, 7'h2A, 8'h5E, 8'($urandom), 1, 0, 0, 0);
        do_frame(2'b11, 1'b0, 7'h2A, 8'h00, 8'($urandom), 1, 0, 0, 0);
        // ena low for 10 cycles mid-SHIFT
        do_frame(2'b10, 1'b0, 7'h15, 8'h00, 8'($urandom), 0, 50, 10, 0);
        // reset at edge 12 of a write, then read the same register back
        do_frame(2'b00, 1'b1, 7'h15, 8'h77, 8'($urandom), 0, 0, 0, 12);
        do_frame(2'b00, 1'b0, 7'h15, 8'h00, 8'($urandom), 0, 0, 0, 0);
        // randomized traffic
        for (int k = 0; k < 12; k++) begin
            do_frame(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 7'($urandom),
                     8'($urandom), 8'($urandom), 0, 0, 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
